daa_dev_table: RTL and testbench

//  Device table downstream of daa_module. Captures each {PID,BCR,DCR} / dynamic

---
 rtl/daa_dev_table.sv | 157 +++++++++++++++
 tb/tb_daa_dev_table.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/daa_dev_table.sv
// Device table fed by ENTDAA results: stores {PID,BCR,DCR}/DA pairs, proposes
// the next dynamic address, and serves indexed reads and DA lookups.
module daa_dev_table #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned AW      = $clog2(DEPTH),
    parameter logic [6:0]  BASE_DA = 7'h08
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_clear,
    input  logic [63:0]   i_pid_bcr_dcr,
    input  logic [6:0]    i_da,
    input  logic          i_pid_da_valid,
    output logic [6:0]    o_next_da,
    output logic [AW:0]   o_count,
    output logic          o_full,
    output logic          o_overflow,
    output logic          o_dup_error,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_idx,
    output logic          o_rd_valid,
    output logic          o_rd_hit,
    output logic [6:0]    o_rd_da,
    output logic [63:0]   o_rd_pid_bcr_dcr,
    input  logic          i_lookup_en,
    input  logic [6:0]    i_lookup_da,
    output logic          o_lookup_done,
    output logic          o_lookup_hit,
    output logic [AW-1:0] o_lookup_idx
);

    localparam int unsigned CW  = AW + 1;
    localparam int unsigned DAW = 7;

    logic [DEPTH-1:0] r_valid;
    logic [6:0]       r_da   [DEPTH];
    logic [63:0]      r_data [DEPTH];
    logic [AW:0]      r_count;
    logic             r_full;
    logic [6:0]       r_next_da;
    logic             r_overflow;
    logic             r_dup_error;
    logic             r_rd_valid;
    logic             r_rd_hit;
    logic [6:0]       r_rd_da;
    logic [63:0]      r_rd_data;
    logic             r_lookup_done;
    logic             r_lookup_hit;
    logic [AW-1:0]    r_lookup_idx;

    logic             w_dup;
    logic             w_lk_hit;
    logic [AW-1:0]    w_lk_idx;
    logic             w_wr_ok;
    logic [AW-1:0]    w_wr_idx;
    logic [AW:0]      w_count_nxt;
    logic             w_rd_hit;

    // Parallel compares; scanning high-to-low leaves the lowest match in w_lk_idx
    always_comb begin
        w_dup    = 1'b0;
        w_lk_hit = 1'b0;
        w_lk_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_da[i] == i_da)) begin
                w_dup = 1'b1;
            end
            if (r_valid[i] && (r_da[i] == i_lookup_da)) begin
                w_lk_hit = 1'b1;
                w_lk_idx = AW'(i);
            end
        end
    end

    assign w_wr_ok     = i_pid_da_valid && !i_clear && !r_full && !w_dup;
    assign w_wr_idx    = r_count[AW-1:0];
    assign w_count_nxt = i_clear ? '0 : (w_wr_ok ? r_count + CW'(1) : r_count);
    assign w_rd_hit    = r_valid[i_rd_idx] && !i_clear;

    // Entry storage; stale data behind a cleared valid bit is never exposed
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_da[i]   <= '0;
                r_data[i] <= '0;
            end
        end else if (i_clear) begin
            r_valid <= '0;
        end else if (w_wr_ok) begin
            r_valid[w_wr_idx] <= 1'b1;
            r_da[w_wr_idx]    <= i_da;
            r_data[w_wr_idx]  <= i_pid_bcr_dcr;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count     <= '0;
            r_full      <= 1'b0;
            r_next_da   <= BASE_DA;
            r_overflow  <= 1'b0;
            r_dup_error <= 1'b0;
        end else begin
            r_count   <= w_count_nxt;
            r_full    <= (w_count_nxt == CW'(DEPTH));
            r_next_da <= BASE_DA + DAW'(w_count_nxt);
            if (i_clear) begin
                r_overflow  <= 1'b0;
                r_dup_error <= 1'b0;
            end else if (i_pid_da_valid && r_full) begin
                r_overflow <= 1'b1;
            end else if (i_pid_da_valid && w_dup) begin
                r_dup_error <= 1'b1;
            end
        end
    end

    // Read/lookup results hold between strobes and see pre-write contents
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rd_valid    <= 1'b0;
            r_rd_hit      <= 1'b0;
            r_rd_da       <= '0;
            r_rd_data     <= '0;
            r_lookup_done <= 1'b0;
            r_lookup_hit  <= 1'b0;
            r_lookup_idx  <= '0;
        end else begin
            r_rd_valid    <= i_rd_en;
            r_lookup_done <= i_lookup_en;
            if (i_rd_en) begin
                r_rd_hit  <= w_rd_hit;
                r_rd_da   <= w_rd_hit ? r_da[i_rd_idx] : '0;
                r_rd_data <= w_rd_hit ? r_data[i_rd_idx] : '0;
            end
            if (i_lookup_en) begin
                r_lookup_hit <= w_lk_hit && !i_clear;
                r_lookup_idx <= (w_lk_hit && !i_clear) ? w_lk_idx : '0;
            end
        end
    end

    assign o_next_da        = r_next_da;
    assign o_count          = r_count;
    assign o_full           = r_full;
    assign o_overflow       = r_overflow;
    assign o_dup_error      = r_dup_error;
    assign o_rd_valid       = r_rd_valid;
    assign o_rd_hit         = r_rd_hit;
    assign o_rd_da          = r_rd_da;
    assign o_rd_pid_bcr_dcr = r_rd_data;
    assign o_lookup_done    = r_lookup_done;
    assign o_lookup_hit     = r_lookup_hit;
    assign o_lookup_idx     = r_lookup_idx;

endmodule

// File: tb/tb_daa_dev_table.sv
// Bench for daa_dev_table: vector table of table operations with expected
// status, plus queued expectations for read/lookup strobes.
module tb_daa_dev_table;

    localparam logic [63:0] P = 64'hDEADBEEFBEEFDEAD;
    localparam int unsigned NV = 19;

    typedef enum logic [1:0] {OP_WR, OP_RD, OP_LK, OP_CLR} op_e;

    typedef struct {
        op_e         op;
        logic [6:0]  da;
        logic [63:0] d;
        logic [2:0]  idx;
        logic [3:0]  e_cnt;
        logic [6:0]  e_nda;
        logic [2:0]  e_flags;
        logic        e_hit;
        logic [6:0]  e_rda;
        logic [63:0] e_rdata;
        logic [2:0]  e_lidx;
    } vec_t;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_clear;
    logic [63:0] i_pid_bcr_dcr;
    logic [6:0]  i_da;
    logic        i_pid_da_valid;
    logic [6:0]  o_next_da;
    logic [3:0]  o_count;
    logic        o_full;
    logic        o_overflow;
    logic        o_dup_error;
    logic        i_rd_en;
    logic [2:0]  i_rd_idx;
    logic        o_rd_valid;
    logic        o_rd_hit;
    logic [6:0]  o_rd_da;
    logic [63:0] o_rd_pid_bcr_dcr;
    logic        i_lookup_en;
    logic [6:0]  i_lookup_da;
    logic        o_lookup_done;
    logic        o_lookup_hit;
    logic [2:0]  o_lookup_idx;

    int n_checks = 0;
    int n_errors = 0;
    logic [71:0] rd_q[$];
    logic [3:0]  lk_q[$];
    vec_t        vecs[NV];

    daa_dev_table dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_clear(i_clear),
        .i_pid_bcr_dcr(i_pid_bcr_dcr), .i_da(i_da), .i_pid_da_valid(i_pid_da_valid),
        .o_next_da(o_next_da), .o_count(o_count), .o_full(o_full),
        .o_overflow(o_overflow), .o_dup_error(o_dup_error),
        .i_rd_en(i_rd_en), .i_rd_idx(i_rd_idx), .o_rd_valid(o_rd_valid),
        .o_rd_hit(o_rd_hit), .o_rd_da(o_rd_da), .o_rd_pid_bcr_dcr(o_rd_pid_bcr_dcr),
        .i_lookup_en(i_lookup_en), .i_lookup_da(i_lookup_da),
        .o_lookup_done(o_lookup_done), .o_lookup_hit(o_lookup_hit),
        .o_lookup_idx(o_lookup_idx)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(op_e op, logic [6:0] da, logic [63:0] d, logic [2:0] idx,
                                logic [3:0] cnt, logic [6:0] nda, logic [2:0] fl,
                                logic hit, logic [6:0] rda, logic [63:0] rdata,
                                logic [2:0] lidx);
        vec_t v;
        v.op = op; v.da = da; v.d = d; v.idx = idx; v.e_cnt = cnt; v.e_nda = nda;
        v.e_flags = fl; v.e_hit = hit; v.e_rda = rda; v.e_rdata = rdata; v.e_lidx = lidx;
        return v;
    endfunction

    task automatic idle();
        i_clear = 1'b0; i_pid_da_valid = 1'b0; i_rd_en = 1'b0; i_lookup_en = 1'b0;
    endtask

    // {count, next_da, full, overflow, dup_error, rd_valid, lookup_done}
    function automatic logic [15:0] status();
        return {o_count, o_next_da, o_full, o_overflow, o_dup_error, o_rd_valid, o_lookup_done};
    endfunction

    // Strobe monitor: pops the oldest queued expectation on every result pulse
    always @(negedge i_clk) begin
        if (!i_reset && o_rd_valid) begin
            if (rd_q.size() == 0) check("rd_unexpected", 128'(1), 128'(0));
            else check("rd_result", 128'({o_rd_hit, o_rd_da, o_rd_pid_bcr_dcr}), 128'(rd_q.pop_front()));
        end
        if (!i_reset && o_lookup_done) begin
            if (lk_q.size() == 0) check("lk_unexpected", 128'(1), 128'(0));
            else check("lk_result", 128'({o_lookup_hit, o_lookup_idx}), 128'(lk_q.pop_front()));
        end
    end

    initial begin
        // {full, overflow, dup}
        vecs[0]  = mk(OP_WR,  7'h08, P,     0, 1, 7'h09, 3'b000, 0, 0, 0, 0);
        vecs[1]  = mk(OP_WR,  7'h09, P + 1, 0, 2, 7'h0A, 3'b000, 0, 0, 0, 0);
        vecs[2]  = mk(OP_WR,  7'h0A, P + 2, 0, 3, 7'h0B, 3'b000, 0, 0, 0, 0);
        vecs[3]  = mk(OP_RD,  7'h00, 0,     1, 3, 7'h0B, 3'b000, 1, 7'h09, P + 1, 0);
        vecs[4]  = mk(OP_LK,  7'h0A, 0,     0, 3, 7'h0B, 3'b000, 1, 0, 0, 2);
        vecs[5]  = mk(OP_LK,  7'h30, 0,     0, 3, 7'h0B, 3'b000, 0, 0, 0, 0);
        vecs[6]  = mk(OP_WR,  7'h09, P + 9, 0, 3, 7'h0B, 3'b001, 0, 0, 0, 0);
        vecs[7]  = mk(OP_RD,  7'h00, 0,     5, 3, 7'h0B, 3'b001, 0, 0, 0, 0);
        vecs[8]  = mk(OP_WR,  7'h0B, P + 3, 0, 4, 7'h0C, 3'b001, 0, 0, 0, 0);
        vecs[9]  = mk(OP_WR,  7'h0C, P + 4, 0, 5, 7'h0D, 3'b001, 0, 0, 0, 0);
        vecs[10] = mk(OP_WR,  7'h0D, P + 5, 0, 6, 7'h0E, 3'b001, 0, 0, 0, 0);
        vecs[11] = mk(OP_WR,  7'h0E, P + 6, 0, 7, 7'h0F, 3'b001, 0, 0, 0, 0);
        vecs[12] = mk(OP_WR,  7'h0F, P + 7, 0, 8, 7'h10, 3'b101, 0, 0, 0, 0);
        vecs[13] = mk(OP_WR,  7'h20, P + 8, 0, 8, 7'h10, 3'b111, 0, 0, 0, 0);
        vecs[14] = mk(OP_LK,  7'h0F, 0,     0, 8, 7'h10, 3'b111, 1, 0, 0, 7);
        vecs[15] = mk(OP_RD,  7'h00, 0,     7, 8, 7'h10, 3'b111, 1, 7'h0F, P + 7, 0);
        vecs[16] = mk(OP_CLR, 7'h11, P,     0, 0, 7'h08, 3'b000, 0, 0, 0, 0);
        vecs[17] = mk(OP_RD,  7'h00, 0,     0, 0, 7'h08, 3'b000, 0, 0, 0, 0);
        vecs[18] = mk(OP_LK,  7'h08, 0,     0, 0, 7'h08, 3'b000, 0, 0, 0, 0);

        i_reset = 1'b1; i_da = '0; i_pid_bcr_dcr = '0; i_rd_idx = '0; i_lookup_da = '0;
        idle();
        repeat (2) @(negedge i_clk);
        check("reset_status", 128'(status()), 128'({4'd0, 7'h08, 5'b00000}));
        i_reset = 1'b0;
        @(negedge i_clk);

        for (int k = 0; k < NV; k++) begin
            case (vecs[k].op)
                OP_WR: begin
                    i_pid_da_valid = 1'b1; i_da = vecs[k].da; i_pid_bcr_dcr = vecs[k].d;
                end
                OP_RD: begin
                    i_rd_en = 1'b1; i_rd_idx = vecs[k].idx;
                    rd_q.push_back({vecs[k].e_hit, vecs[k].e_rda, vecs[k].e_rdata});
                end
                OP_LK: begin
                    i_lookup_en = 1'b1; i_lookup_da = vecs[k].da;
                    lk_q.push_back({vecs[k].e_hit, vecs[k].e_lidx});
                end
                default: begin
                    i_clear = 1'b1; i_pid_da_valid = 1'b1;
                    i_da = vecs[k].da; i_pid_bcr_dcr = vecs[k].d;
                end
            endcase
            @(negedge i_clk);
            idle();
            check($sformatf("vec%0d_status", k), 128'(status()),
                  128'({vecs[k].e_cnt, vecs[k].e_nda, vecs[k].e_flags,
                        vecs[k].op == OP_RD, vecs[k].op == OP_LK}));
        end

        // Same-cycle write + lookup of the same DA sees the empty table
        i_pid_da_valid = 1'b1; i_da = 7'h08; i_pid_bcr_dcr = P + 16;
        i_lookup_en = 1'b1; i_lookup_da = 7'h08; lk_q.push_back({1'b0, 3'd0});
        @(negedge i_clk);
        idle();
        // Back-to-back: lookup+read now hit, then a read colliding with clear misses
        i_lookup_en = 1'b1; i_lookup_da = 7'h08; lk_q.push_back({1'b1, 3'd0});
        i_rd_en = 1'b1; i_rd_idx = 3'd0; rd_q.push_back({1'b1, 7'h08, P + 16});
        @(negedge i_clk);
        idle();
        i_rd_en = 1'b1; i_rd_idx = 3'd0; i_clear = 1'b1; rd_q.push_back({1'b0, 7'h00, 64'h0});
        @(negedge i_clk);
        idle();
        check("clear_after_fill", 128'(status()), 128'({4'd0, 7'h08, 5'b00010}));

        // Asynchronous reset mid-operation drops table state before any edge
        i_pid_da_valid = 1'b1; i_da = 7'h21; i_pid_bcr_dcr = P;
        @(negedge i_clk);
        idle();
        check("pre_reset_count", 128'(o_count), 128'(1));
        i_pid_da_valid = 1'b1; i_da = 7'h22;
        #2 i_reset = 1'b1;
        #1 check("async_reset", 128'(status()), 128'({4'd0, 7'h08, 5'b00000}));
        @(negedge i_clk);
        idle();
        i_reset = 1'b0;
        @(negedge i_clk);
        check("post_reset", 128'(status()), 128'({4'd0, 7'h08, 5'b00000}));

        repeat (3) @(negedge i_clk);
        check("rd_q_drained", 128'(rd_q.size()), 128'(0));
        check("lk_q_drained", 128'(lk_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
